// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for the external NOT/NAND/NOR gate unit: sweeps all four a/b vectors and tallies mismatches.
// Build option: define GATE_SEQ_STOP_ON_FAIL_EN to end the sweep at the first vector that shows a mismatch.
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y0,
    input  logic             gate_y1,
    input  logic             gate_y2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [1:0]       vec_idx
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // DRIVE  | register a/b for the current vector, load settle counter
    // SETTLE | let the gate outputs settle for SETTLE_CYCLES cycles
    // SAMPLE | compare y0/y1/y2 against golden values and update tallies
    // DONE   | results held until the next start
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [ERR_W+1:0] ERR_MAX     = (ERR_W+2)'((1 << ERR_W) - 1);

    state_t           state;
    logic [7:0]       settle_cnt;
    logic [2:0]       golden;
    logic [2:0]       diff;
    logic [1:0]       mism_n;
    logic             any_mism;
    logic [ERR_W+1:0] err_sum;
    logic [ERR_W-1:0] err_next;
    logic             last_vec;

    // Golden values come from vec_idx, which is exactly what was registered onto gate_a/gate_b.
    always_comb begin
        golden   = {~(vec_idx[1] | vec_idx[0]), ~(vec_idx[1] & vec_idx[0]), ~vec_idx[1]};
        diff     = golden ^ {gate_y2, gate_y1, gate_y0};
        mism_n   = {1'b0, diff[0]} + {1'b0, diff[1]} + {1'b0, diff[2]};
        any_mism = |diff;
        err_sum  = {2'b00, err_count} + (ERR_W+2)'(mism_n);
        err_next = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        last_vec = (vec_idx == 2'd3) || any_mism;
`else
        last_vec = (vec_idx == 2'd3);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 4'b0000;
            vec_idx    <= 2'd0;
            settle_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= '0;
                        fail_vec  <= 4'b0000;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        vec_idx   <= 2'd0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    gate_a     <= vec_idx[1];
                    gate_b     <= vec_idx[0];
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt <= 8'd1) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    if (any_mism) begin
                        fail_vec[vec_idx] <= 1'b1;
                    end
                    if (last_vec) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        vec_idx <= vec_idx + 2'd1;
                        state   <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer: two instances (settle 2 / err width 4, settle 0 / err width 2)
// driven by directed and randomized fault patterns; a monitor pops expectations whenever done rises.
module tb_gate_test_sequencer;

    typedef struct {
        int err;
        int fail;
        int pass;
        int vidx;
        int nvec;
        int start_edge;
        int sel;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] ga, gb, y0, y1, y2, busy, done, pass;
    logic [3:0] err_a;
    logic [1:0] err_b;
    logic [3:0] fail_a, fail_b;
    logic [1:0] vidx_a, vidx_b;
    logic [2:0] s0m, s1m;
    logic [1:0] done_prev;

    int   cyc;
    int   checks;
    int   passed;
    exp_t sbq[$];

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    gate_test_sequencer #(.SETTLE_CYCLES(2), .ERR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .gate_a(ga[0]), .gate_b(gb[0]),
        .gate_y0(y0[0]), .gate_y1(y1[0]), .gate_y2(y2[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_a), .fail_vec(fail_a), .vec_idx(vidx_a)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(0), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .gate_a(ga[1]), .gate_b(gb[1]),
        .gate_y0(y0[1]), .gate_y1(y1[1]), .gate_y2(y2[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_b), .fail_vec(fail_b), .vec_idx(vidx_b)
    );

    // Gate units with injectable stuck-at faults (stuck-at-1 dominates).
    assign {y2[0], y1[0], y0[0]} = ({~(ga[0] | gb[0]), ~(ga[0] & gb[0]), ~ga[0]} & ~s0m) | s1m;
    assign {y2[1], y1[1], y0[1]} = ({~(ga[1] | gb[1]), ~(ga[1] & gb[1]), ~ga[1]} & ~s0m) | s1m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settle_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    function automatic int errmax_of(input int s);
        return (s == 0) ? 15 : 3;
    endfunction

    function automatic int err_of(input int s);
        return (s == 0) ? int'(err_a) : int'(err_b);
    endfunction

    function automatic int fail_of(input int s);
        return (s == 0) ? int'(fail_a) : int'(fail_b);
    endfunction

    function automatic int vidx_of(input int s);
        return (s == 0) ? int'(vidx_a) : int'(vidx_b);
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    endtask

    function automatic exp_t mk(input int err, input int fail, input int ps, input int vidx, input int nvec);
        exp_t e;
        e.err = err; e.fail = fail; e.pass = ps; e.vidx = vidx; e.nvec = nvec;
        e.start_edge = 0; e.sel = 0;
        return e;
    endfunction

    // Reference: walk the four vectors, count wrong output bits from the truth table and the fault masks.
    function automatic exp_t model(input int s, input logic [2:0] m0, input logic [2:0] m1);
        exp_t e;
        int   gold[3];
        int   m;
        int   a, b, act;
        e = mk(0, 0, 0, 0, 0);
        for (int v = 0; v < 4; v++) begin
            a = v / 2;
            b = v % 2;
            gold[0] = (a == 0) ? 1 : 0;
            gold[1] = (a == 1 && b == 1) ? 0 : 1;
            gold[2] = (a == 0 && b == 0) ? 1 : 0;
            m = 0;
            for (int k = 0; k < 3; k++) begin
                act = m1[k] ? 1 : (m0[k] ? 0 : gold[k]);
                if (act != gold[k]) m++;
            end
            e.err = (e.err + m > errmax_of(s)) ? errmax_of(s) : e.err + m;
            if (m > 0) e.fail = e.fail | (1 << v);
            e.nvec = e.nvec + 1;
            e.vidx = v;
            if (STOP && m > 0) break;
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check_reset_outputs(input int s, input string tag);
        chk({tag, "_busy"}, int'(busy[s]), 0);
        chk({tag, "_done"}, int'(done[s]), 0);
        chk({tag, "_pass"}, int'(pass[s]), 0);
        chk({tag, "_err"}, err_of(s), 0);
        chk({tag, "_fail_vec"}, fail_of(s), 0);
        chk({tag, "_vec_idx"}, vidx_of(s), 0);
        chk({tag, "_gate_ab"}, int'({ga[s], gb[s]}), 0);
    endtask

    // Issue one sweep; optionally check busy/gate sequence edge by edge and poke start while busy.
    task automatic run(input int s, input exp_t e_in, input bit check_seq, input bit poke_busy);
        exp_t e;
        int   per, total, rel, waited;
        e   = e_in;
        per = settle_of(s) + 2;
        total = e.nvec * per;
        @(negedge clk);
        start[s] = 1'b1;
        e.start_edge = cyc + 1;
        e.sel = s;
        sbq.push_back(e);
        @(negedge clk);
        start[s] = 1'b0;
        rel = cyc - e.start_edge;
        while (rel < total) begin
            if (check_seq) begin
                chk("busy_during_sweep", int'(busy[s]), 1);
                for (int k = 0; k < e.nvec; k++)
                    if (rel == 1 + k * per) chk("gate_ab_vector", int'({ga[s], gb[s]}), k);
            end
            if (poke_busy && rel == 3) start[s] = 1'b1;
            else start[s] = 1'b0;
            @(negedge clk);
            rel = cyc - e.start_edge;
        end
        start[s] = 1'b0;
        waited = 0;
        while (sbq.size() != 0 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL done_timeout: sel %0d done not seen within budget", s);
            sbq.delete();
        end
        chk("busy_after_done", int'(busy[s]), 0);
        chk("done_held", int'(done[s]), 1);
    endtask

    initial begin : monitor
        exp_t e;
        done_prev = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (done[s] && !done_prev[s]) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_done: sel %0d raised done with nothing expected", s);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_sel", s, e.sel);
                        chk("done_edge", cyc - e.start_edge, e.nvec * (settle_of(s) + 2));
                        chk("err_count", err_of(s), e.err);
                        chk("fail_vec", fail_of(s), e.fail);
                        chk("pass", int'(pass[s]), e.pass);
                        chk("vec_idx", vidx_of(s), e.vidx);
                    end
                end
            end
            done_prev = done;
        end
    end

    initial begin : stim
        int   per, rel, st_edge;
        exp_t e;
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        start  = 2'b00;
        s0m    = 3'b000;
        s1m    = 3'b000;
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "reset_a");
        check_reset_outputs(1, "reset_b");
        rst_n = 1'b1;
        @(negedge clk);

        // Correct gate, settle 2: full sequence, busy window, done at edge 16.
        run(0, mk(0, 0, 1, 3, 4), 1'b1, 1'b0);

        // y1 stuck-at-0.
        s0m = 3'b010;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        run(0, mk(1, 1, 0, 0, 1), 1'b1, 1'b0);
`else
        run(0, mk(3, 7, 0, 3, 4), 1'b1, 1'b0);
`endif

        // y2 stuck-at-1 plus y0 stuck-at-0.
        s0m = 3'b001;
        s1m = 3'b100;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        run(0, mk(1, 1, 0, 0, 1), 1'b0, 1'b0);
`else
        run(0, mk(5, 15, 0, 3, 4), 1'b0, 1'b0);
`endif

        // Settle 0: start while busy ignored, then restart from DONE with cleared tallies.
        s0m = 3'b000;
        s1m = 3'b000;
        run(1, mk(0, 0, 1, 3, 4), 1'b1, 1'b1);
        s0m = 3'b111;
        run(1, model(1, 3'b111, 3'b000), 1'b0, 1'b0);
        s0m = 3'b000;
        run(1, mk(0, 0, 1, 3, 4), 1'b0, 1'b1);

        // Async reset while vector 2 is settling.
        per = settle_of(0) + 2;
        @(negedge clk);
        start[0] = 1'b1;
        st_edge = cyc + 1;
        sbq.push_back(mk(0, 0, 1, 3, 4));
        @(negedge clk);
        start[0] = 1'b0;
        rel = cyc - st_edge;
        while (rel < 2 * per + 2) begin
            @(negedge clk);
            rel = cyc - st_edge;
        end
        chk("gate_a_before_reset", int'(ga[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "async_reset");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(0, mk(0, 0, 1, 3, 4), 1'b0, 1'b0);

        // Random fault patterns on either instance.
        for (int i = 0; i < 24; i++) begin
            int s;
            s   = int'($urandom_range(0, 1));
            s0m = 3'($urandom_range(0, 7));
            s1m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            e   = model(s, s0m, s1m);
            run(s, e, 1'b0, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
